// File: rtl/msx_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | msx_arb_pkg: shared types and constants for the SDRAM arbiter    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package msx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CPU_WAIT   = 2'd1,
    FLASH_WAIT = 2'd2
  } arb_state_t;

  localparam logic [7:0] RD_TIMEOUT_DATA = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/msx_arb_timeout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | msx_arb_timeout: 8-bit ack watchdog, expires on the ACK_TIMEOUT-th |
// | enabled cycle after a clear. Rev 1.0                              |
// +------------------------------------------------------------------+
module msx_arb_timeout #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] c_LIMIT = 8'(ACK_TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (clr) begin
      r_count <= 8'd0;
    end else if (en) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Count 0 is the first wait cycle, so c_LIMIT marks the last one allowed.
  assign expired = en && (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/msx_sdram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | msx_sdram_arbiter: CPU-priority SDRAM front end with a 1-deep     |
// | flash write buffer and ack timeout. Rev 1.0                       |
// +------------------------------------------------------------------+
module msx_sdram_arbiter
  import msx_arb_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rnw,
  input  logic        cpu_ce,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait,
  input  logic [26:0] flash_addr,
  input  logic [7:0]  flash_din,
  input  logic        flash_req,
  output logic        flash_ready,
  output logic        flash_done,
  output logic [26:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic [7:0]  sdram_dout,
  output logic        timeout_err
);

  arb_state_t  r_state;
  logic        r_cpu_served;
  logic [26:0] r_flash_addr;
  logic [7:0]  r_flash_din;
  logic        w_cpu_pending;
  logic        w_expired;
  logic        w_done;

  assign w_cpu_pending = cpu_ce & ~r_cpu_served;
  assign cpu_wait      = w_cpu_pending;
  assign w_done        = sdram_ack | w_expired;

  msx_arb_timeout #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (r_state == IDLE),
    .en      (r_state != IDLE),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cpu_served <= 1'b0;
      r_flash_addr <= 27'd0;
      r_flash_din  <= 8'd0;
      cpu_rdata    <= RD_TIMEOUT_DATA;
      flash_ready  <= 1'b1;
      flash_done   <= 1'b0;
      sdram_addr   <= 27'd0;
      sdram_din    <= 8'd0;
      sdram_we     <= 1'b0;
      sdram_req    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sdram_req  <= 1'b0;
      flash_done <= 1'b0;

      if (!cpu_ce) begin
        r_cpu_served <= 1'b0;
      end

      if (flash_req && flash_ready) begin
        r_flash_addr <= flash_addr;
        r_flash_din  <= flash_din;
        flash_ready  <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_cpu_pending) begin
            sdram_addr <= cpu_addr;
            sdram_din  <= cpu_wdata;
            sdram_we   <= ~cpu_rnw;
            sdram_req  <= 1'b1;
            r_state    <= CPU_WAIT;
          end else if (!flash_ready) begin
            sdram_addr <= r_flash_addr;
            sdram_din  <= r_flash_din;
            sdram_we   <= 1'b1;
            sdram_req  <= 1'b1;
            r_state    <= FLASH_WAIT;
          end
        end

        CPU_WAIT: begin
          if (w_done) begin
            // sdram_we still holds the direction of the access in flight.
            if (!sdram_we) begin
              cpu_rdata <= sdram_ack ? sdram_dout : RD_TIMEOUT_DATA;
            end
            if (!sdram_ack) begin
              timeout_err <= 1'b1;
            end
            if (cpu_ce) begin
              r_cpu_served <= 1'b1;
            end
            r_state <= IDLE;
          end
        end

        FLASH_WAIT: begin
          if (w_done) begin
            if (!sdram_ack) begin
              timeout_err <= 1'b1;
            end
            flash_done  <= 1'b1;
            flash_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msx_sdram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_msx_sdram_arbiter: scoreboard bench for msx_sdram_arbiter      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_msx_sdram_arbiter;

  typedef struct packed {
    logic [26:0] addr;
    logic [7:0]  din;
    logic        we;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rnw;
  logic        cpu_ce;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic [26:0] flash_addr;
  logic [7:0]  flash_din;
  logic        flash_req;
  logic        flash_ready;
  logic        flash_done;
  logic [26:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_we;
  logic        sdram_req;
  logic        sdram_ack;
  logic [7:0]  sdram_dout;
  logic        timeout_err;

  int   checks = 0;
  int   errors = 0;
  int   n_req  = 0;
  int   n_done = 0;
  req_t exp_q[$];
  req_t got_e;

  always #5 clk = ~clk;

  msx_sdram_arbiter #(.ACK_TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rnw     (cpu_rnw),
    .cpu_ce      (cpu_ce),
    .cpu_rdata   (cpu_rdata),
    .cpu_wait    (cpu_wait),
    .flash_addr  (flash_addr),
    .flash_din   (flash_din),
    .flash_req   (flash_req),
    .flash_ready (flash_ready),
    .flash_done  (flash_done),
    .sdram_addr  (sdram_addr),
    .sdram_din   (sdram_din),
    .sdram_we    (sdram_we),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_dout  (sdram_dout),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every issued request is compared against the oldest expected one.
  always @(negedge clk) begin
    if (reset && sdram_req) begin
      n_req++;
      if (exp_q.size() == 0) begin
        check("unexpected_req", 32'd1, 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("req_addr", {5'd0, sdram_addr}, {5'd0, got_e.addr});
        check("req_din", {24'd0, sdram_din}, {24'd0, got_e.din});
        check("req_we", {31'd0, sdram_we}, {31'd0, got_e.we});
      end
    end
  end

  always @(negedge clk) begin
    if (reset && flash_done) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (sdram_req) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic ack_now(input logic [7:0] data);
    sdram_ack  = 1'b1;
    sdram_dout = data;
    step();
    sdram_ack  = 1'b0;
    sdram_dout = 8'h00;
  endtask

  initial begin
    int r0, d0;
    reset = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_rnw = 1'b1; cpu_ce = 1'b0;
    flash_addr = '0; flash_din = '0; flash_req = 1'b0; sdram_ack = 1'b0; sdram_dout = '0;
    repeat (3) step();
    check("rst_rdata", {24'd0, cpu_rdata}, 32'hFF);
    check("rst_ready", {31'd0, flash_ready}, 32'd1);
    check("rst_tmo", {31'd0, timeout_err}, 32'd0);
    check("rst_req", {31'd0, sdram_req}, 32'd0);
    check("rst_we", {31'd0, sdram_we}, 32'd0);
    check("rst_addr", {5'd0, sdram_addr}, 32'd0);
    check("rst_done", {31'd0, flash_done}, 32'd0);
    check("rst_wait", {31'd0, cpu_wait}, 32'd0);
    reset = 1'b1;
    step();

    // CPU read, ack 4 cycles after the request
    r0 = n_req;
    exp_q.push_back('{addr: 27'h0012345, din: 8'h00, we: 1'b0});
    cpu_addr = 27'h0012345; cpu_rnw = 1'b1; cpu_wdata = 8'h00; cpu_ce = 1'b1;
    #1 check("rd_wait_c0", {31'd0, cpu_wait}, 32'd1);
    step();
    check("rd_req_c1", {31'd0, sdram_req}, 32'd1);
    repeat (4) step();
    check("rd_wait_c5", {31'd0, cpu_wait}, 32'd1);
    ack_now(8'hA5);
    check("rd_wait_c6", {31'd0, cpu_wait}, 32'd0);
    check("rd_data", {24'd0, cpu_rdata}, 32'hA5);
    repeat (5) step();
    check("rd_one_req", n_req - r0, 32'd1);
    cpu_ce = 1'b0;
    step();

    // Flash write
    d0 = n_done;
    exp_q.push_back('{addr: 27'h0100000, din: 8'h3C, we: 1'b1});
    flash_addr = 27'h0100000; flash_din = 8'h3C; flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    check("fl_ready_low", {31'd0, flash_ready}, 32'd0);
    wait_req(10);
    step(); step();
    ack_now(8'h00);
    check("fl_done", {31'd0, flash_done}, 32'd1);
    check("fl_ready_high", {31'd0, flash_ready}, 32'd1);
    step();
    check("fl_done_count", n_done - d0, 32'd1);

    // Contention: CPU write and flash request together
    exp_q.push_back('{addr: 27'h0000777, din: 8'h55, we: 1'b1});
    exp_q.push_back('{addr: 27'h0200000, din: 8'hC3, we: 1'b1});
    cpu_addr = 27'h0000777; cpu_wdata = 8'h55; cpu_rnw = 1'b0; cpu_ce = 1'b1;
    flash_addr = 27'h0200000; flash_din = 8'hC3; flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    check("ct_cpu_first", {31'd0, sdram_req}, 32'd1);
    step(); step();
    cpu_ce = 1'b0;
    ack_now(8'h00);
    check("ct_rdata_kept", {24'd0, cpu_rdata}, 32'hA5);
    d0 = n_done;
    wait_req(10);
    step();
    ack_now(8'h00);
    step();
    check("ct_fl_done", n_done - d0, 32'd1);
    check("ct_sb_drained", exp_q.size(), 32'd0);

    // Timeout on a CPU read
    exp_q.push_back('{addr: 27'h0ABCDEF, din: 8'h00, we: 1'b0});
    cpu_addr = 27'h0ABCDEF; cpu_wdata = 8'h00; cpu_rnw = 1'b1; cpu_ce = 1'b1;
    step();
    check("to_req_c1", {31'd0, sdram_req}, 32'd1);
    repeat (7) step();
    check("to_err_c8", {31'd0, timeout_err}, 32'd0);
    check("to_wait_c8", {31'd0, cpu_wait}, 32'd1);
    step();
    check("to_err_c9", {31'd0, timeout_err}, 32'd1);
    check("to_rdata", {24'd0, cpu_rdata}, 32'hFF);
    check("to_wait_c9", {31'd0, cpu_wait}, 32'd0);
    cpu_ce = 1'b0;
    repeat (4) step();
    check("to_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset while waiting on a flash write, then a stray ack
    exp_q.push_back('{addr: 27'h0300000, din: 8'h11, we: 1'b1});
    flash_addr = 27'h0300000; flash_din = 8'h11; flash_req = 1'b1;
    step();
    flash_req = 1'b0;
    wait_req(10);
    step();
    r0 = n_req; d0 = n_done;
    reset = 1'b0;
    step();
    reset = 1'b1;
    ack_now(8'h00);
    repeat (4) step();
    check("rs_ready", {31'd0, flash_ready}, 32'd1);
    check("rs_no_done", n_done - d0, 32'd0);
    check("rs_no_req", n_req - r0, 32'd0);
    check("rs_tmo_clr", {31'd0, timeout_err}, 32'd0);

    // Second flash request while the buffer is full is dropped
    exp_q.push_back('{addr: 27'h0400000, din: 8'h22, we: 1'b1});
    flash_addr = 27'h0400000; flash_din = 8'h22; flash_req = 1'b1;
    step();
    flash_addr = 27'h0500000; flash_din = 8'h33;
    step();
    flash_req = 1'b0;
    r0 = n_req;
    wait_req(10);
    step();
    ack_now(8'h00);
    repeat (6) step();
    check("ig_one_req", n_req - r0, 32'd1);
    check("ig_ready", {31'd0, flash_ready}, 32'd1);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
